// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter. It sends one command byte:
// clock inhibit, request-to-send, then 8 data bits (LSB first), odd parity
// and stop, shifted out on device clock falling edges, then the device ACK
// is checked.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer that the
// device never completes; without it tx_timeout is tied low and the block
// waits for the device indefinitely.
//
// Request handshake: tx_req is a request qualified by tx_ready. A byte is
// accepted in the cycle where tx_req & tx_ready are both 1. tx_data is
// captured in that same cycle. tx_req while busy is dropped and is not
// queued.
module ps2_tx #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int INHIBIT_US   = 100,
  parameter int TIMEOUT_US   = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_o,
  output logic       ps2_clk_w,
  output logic       ps2_data_o,
  output logic       ps2_data_w,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_MHZ * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ_MHZ * TIMEOUT_US;
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  // Both durations must be at least one clock cycle.
  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_tx: INHIBIT and TIMEOUT must be at least one cycle");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_REL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             clk_meta;
  logic             clk_s;
  logic             clk_s_d1;
  logic             data_meta;
  logic             data_s;
  logic             clk_fall;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shift_q;
  logic             data_drv;
  logic             ack_err_q;
  logic             timeout_hit;

  // The lines idle high, so the synchronisers reset to 1. This avoids a false
  // falling edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_s_d1  <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_s     <= clk_meta;
      clk_s_d1  <= clk_s;
      data_meta <= ps2_data_i;
      data_s    <= data_meta;
    end
  end

  assign clk_fall = ~clk_s & clk_s_d1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            active;

  assign active = (state == S_RTS) || (state == S_SHIFT) ||
                  (state == S_ACK) || (state == S_WAIT_REL);

  // The watchdog counts from request-to-send until the frame ends. It is cleared whenever the block is inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      to_cnt <= '0;
    else if (active) to_cnt <= to_cnt + TO_W'(1);
    else             to_cnt <= '0;
  end

  assign timeout_hit = active && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Register the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the completion pulses. tx_done has priority over a coincident timeout.
  always_comb begin
    state_nxt  = state;
    tx_done    = 1'b0;
    tx_timeout = 1'b0;
    case (state)
      S_IDLE:     if (tx_req) state_nxt = S_INHIBIT;
      S_INHIBIT:  if (inh_cnt == INH_LAST) state_nxt = S_RTS;
      S_RTS:      state_nxt = S_SHIFT;
      S_SHIFT:    if (clk_fall && (bit_cnt == 4'd9)) state_nxt = S_ACK;
      S_ACK:      if (clk_fall) state_nxt = S_WAIT_REL;
      S_WAIT_REL: begin
        if (clk_s && data_s) begin
          tx_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:    state_nxt = S_IDLE;
    endcase
    if (timeout_hit && !tx_done) begin
      tx_timeout = 1'b1;
      state_nxt  = S_IDLE;
    end
  end

  // Datapath: capture the byte, time the inhibit, shift a bit out per device clock fall, and sample the ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data_drv  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          inh_cnt <= '0;
          if (tx_req) begin
            shift_q   <= {~^tx_data, tx_data};
            ack_err_q <= 1'b0;
          end
        end
        S_INHIBIT: inh_cnt <= inh_cnt + INH_W'(1);
        S_RTS: begin
          bit_cnt  <= '0;
          data_drv <= 1'b1;
        end
        S_SHIFT: begin
          if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              data_drv <= 1'b0;
            end else begin
              data_drv <= ~shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end
        S_ACK:   if (clk_fall) ack_err_q <= data_s;
        default: ;
      endcase
    end
  end

  // The drive enables decode only from flops that reset asynchronously, so reset releases the lines at once.
  assign ps2_clk_w  = (state == S_INHIBIT) || (state == S_RTS);
  assign ps2_data_w = (state == S_RTS) || ((state == S_SHIFT) && data_drv);
  assign ps2_clk_o  = 1'b0;
  assign ps2_data_o = 1'b0;
  assign tx_ready   = (state == S_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_ack_err = ack_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx. An open-drain PS/2 device model clocks at a
// 40-cycle period. Optional watchdog coverage is built in when
// PS2_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_o, ps2_clk_w, ps2_data_o, ps2_data_w;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   to_pulses = 0;
  logic done_err = 1'b0;

  // Wired-AND open-drain lines: the host and the device can each only pull low.
  assign ps2_clk_i  = ~(ps2_clk_w | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_w | dev_data_low);

  ps2_tx #(
    .CLK_FREQ_MHZ(1),
    .INHIBIT_US  (10),
    .TIMEOUT_US  (2000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_o (ps2_clk_o),
    .ps2_clk_w (ps2_clk_w),
    .ps2_data_o(ps2_data_o),
    .ps2_data_w(ps2_data_w),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts completions and checks that the pulses are exclusive and that tx_ready is low while a pulse is high.
  always @(negedge clk) begin
    if (tx_done || tx_timeout) begin
      check("pulse_exclusive", {31'b0, tx_done & tx_timeout}, 32'd0);
      check("ready_low_at_pulse", {31'b0, tx_ready}, 32'd0);
    end
    if (tx_done) begin
      done_cnt++;
      done_err = tx_ack_err;
    end
    if (tx_timeout) to_pulses++;
  end

  // Issue a request, then measure the inhibit length, the RTS overlap and the clock release.
  task automatic host_send(input logic [7:0] d, output int inh,
                           output logic rts_ok, output logic fall_ok);
    @(negedge clk);
    tx_req  = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = ~d;
    inh = 0;
    while (ps2_clk_w && !ps2_data_w && inh < 100) begin
      inh++;
      @(negedge clk);
    end
    rts_ok = ps2_clk_w & ps2_data_w;
    @(negedge clk);
    fall_ok = ~ps2_clk_w & ps2_data_w;
  endtask

  // Device side: clock out 10 bits, sample each on the rising edge, then run the ACK pulse.
  task automatic dev_frame(input logic ack, output logic [10:0] bits);
    bits = '0;
    for (int i = 0; i < 100 && !(!ps2_clk_w && !ps2_data_i); i++) @(negedge clk);
    repeat (10) @(negedge clk);
    bits[0] = ps2_data_i;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      bits[k] = ps2_data_i;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 200 && done_cnt == prev; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int          inh;
    int          prev;
    int          prev_to;
    int          k;
    logic        rts_ok;
    logic        fall_ok;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_clk_w", {31'b0, ps2_clk_w}, 32'd0);
    check("rst_data_w", {31'b0, ps2_data_w}, 32'd0);
    check("rst_done", {31'b0, tx_done}, 32'd0);
    check("rst_ack_err", {31'b0, tx_ack_err}, 32'd0);
    check("rst_timeout", {31'b0, tx_timeout}, 32'd0);
    check("drive_vals", {30'b0, ps2_clk_o, ps2_data_o}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with ACK. This frame also checks the inhibit and RTS timing.
    prev = done_cnt;
    host_send(8'hED, inh, rts_ok, fall_ok);
    check("inhibit_cycles", inh, 32'd10);
    check("rts_overlap", {31'b0, rts_ok}, 32'd1);
    check("clk_release_after_rts", {31'b0, fall_ok}, 32'd1);
    check("busy_in_frame", {31'b0, tx_busy}, 32'd1);
    dev_frame(1'b1, bits);
    check("frame_ED", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'hED, 1'b0});
    wait_done(prev);
    check("done_ED", done_cnt - prev, 32'd1);
    check("ack_ok_ED", {31'b0, done_err}, 32'd0);
    check("ready_after_ED", {31'b0, tx_ready}, 32'd1);
    check("lines_idle_ED", {30'b0, ps2_clk_w, ps2_data_w}, 32'd0);

    // 0x00 with no ACK from the device
    prev = done_cnt;
    host_send(8'h00, inh, rts_ok, fall_ok);
    dev_frame(1'b0, bits);
    check("frame_00", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'h00, 1'b0});
    wait_done(prev);
    check("done_00", done_cnt - prev, 32'd1);
    check("ack_err_00", {31'b0, done_err}, 32'd1);
    check("ack_err_held", {31'b0, tx_ack_err}, 32'd1);

    // 0xF4 with a 0x55 request while busy. Only 0xF4 goes out, with one tx_done.
    prev = done_cnt;
    host_send(8'hF4, inh, rts_ok, fall_ok);
    tx_req  = 1'b1;
    tx_data = 8'h55;
    repeat (5) @(negedge clk);
    tx_req  = 1'b0;
    check("ack_err_kept_busy", {31'b0, tx_ack_err}, 32'd0);
    dev_frame(1'b1, bits);
    check("frame_F4", {21'b0, bits}, {21'b0, 1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done(prev);
    repeat (40) @(negedge clk);
    check("single_done_F4", done_cnt - prev, 32'd1);
    check("ack_ok_F4", {31'b0, done_err}, 32'd0);
    check("idle_after_F4", {30'b0, tx_ready, ps2_clk_w}, 32'd2);

`ifdef PS2_TX_TIMEOUT_EN
    // The device never clocks. The watchdog fires 2000 cycles after RTS.
    prev    = done_cnt;
    prev_to = to_pulses;
    host_send(8'h3C, inh, rts_ok, fall_ok);
    k = 1;
    while (!tx_timeout && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 32'd2000);
    @(negedge clk);
    check("timeout_lines", {30'b0, ps2_clk_w, ps2_data_w}, 32'd0);
    check("timeout_ready", {31'b0, tx_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("timeout_pulses", to_pulses - prev_to, 32'd1);
    check("timeout_no_done", done_cnt - prev, 32'd0);
`else
    // Without the watchdog the block keeps waiting for a silent device.
    prev = done_cnt;
    host_send(8'h3C, inh, rts_ok, fall_ok);
    repeat (2500) @(negedge clk);
    check("no_timeout_pulse", to_pulses, 32'd0);
    check("still_busy", {31'b0, tx_busy}, 32'd1);
    check("still_start_bit", {30'b0, ps2_clk_w, ps2_data_w}, 32'd1);
    check("no_done_waiting", done_cnt - prev, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif

    // Reset while bit 3 of 0x00 is on the line. Then 0xAA must send cleanly.
    prev = done_cnt;
    host_send(8'h00, inh, rts_ok, fall_ok);
    for (int p = 0; p < 3; p++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    check("bit3_driven_low", {31'b0, ps2_data_w}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk_w", {31'b0, ps2_clk_w}, 32'd0);
    check("rst_mid_data_w", {31'b0, ps2_data_w}, 32'd0);
    check("rst_mid_ready", {31'b0, tx_ready}, 32'd1);
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", done_cnt - prev, 32'd0);
    prev = done_cnt;
    host_send(8'hAA, inh, rts_ok, fall_ok);
    dev_frame(1'b1, bits);
    check("frame_AA", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'hAA, 1'b0});
    wait_done(prev);
    check("done_AA", done_cnt - prev, 32'd1);
    check("ack_ok_AA", {31'b0, done_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
